// File: rtl/joystick_selector.sv
// Joystick-driven value selector: a press steps the value once, holding it auto-repeats
// after FIRST_DELAY and then every REPEAT_DELAY cycles, with release hysteresis.
module joystick_selector #(
   parameter int ADC_W        = 12,
   parameter int VAL_W        = 4,
   parameter int MAX_VAL      = 2**VAL_W-1,
   parameter int RESET_VAL    = 0,
   parameter int HI_THRESH    = 12'h750,
   parameter int LO_THRESH    = 12'h500,
   parameter int HYST         = 12'h040,
   parameter int FIRST_DELAY  = 5000000,
   parameter int REPEAT_DELAY = 1250000,
   parameter int WRAP         = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [ADC_W-1:0] axis_value,
   input  logic             load,
   input  logic [VAL_W-1:0] load_value,
   output logic [VAL_W-1:0] value,
   output logic             step_up,
   output logic             step_down,
   output logic             held,
   output logic             at_limit
);

   localparam int MAX_DELAY = (FIRST_DELAY > REPEAT_DELAY) ? FIRST_DELAY : REPEAT_DELAY;
   localparam int CNT_W     = $clog2(MAX_DELAY);

   localparam logic [CNT_W-1:0] FIRST_LAST  = CNT_W'(FIRST_DELAY - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [ADC_W-1:0] PRESS_UP    = ADC_W'(HI_THRESH);
   localparam logic [ADC_W-1:0] PRESS_DN    = ADC_W'(LO_THRESH);
   localparam logic [ADC_W-1:0] RELEASE_UP  = ADC_W'(HI_THRESH - HYST);
   localparam logic [ADC_W-1:0] RELEASE_DN  = ADC_W'(LO_THRESH + HYST);
   localparam logic [VAL_W-1:0] MAX_V       = VAL_W'(MAX_VAL);
   localparam logic [VAL_W-1:0] RESET_V     = VAL_W'(RESET_VAL);

   typedef enum logic [1:0] {IDLE, FIRST, REPEAT} state_t;
   typedef enum logic {DIR_UP, DIR_DN} dir_t;

   // Step helpers return {refused, next_value}; refused is only ever set in saturate mode.
   function automatic logic [VAL_W:0] inc_val(input logic [VAL_W-1:0] v);
      if (v >= MAX_V)
         return (WRAP != 0) ? {1'b0, {VAL_W{1'b0}}} : {1'b1, v};
      return {1'b0, v + VAL_W'(1)};
   endfunction

   function automatic logic [VAL_W:0] dec_val(input logic [VAL_W-1:0] v);
      if (v == '0)
         return (WRAP != 0) ? {1'b0, MAX_V} : {1'b1, v};
      return {1'b0, v - VAL_W'(1)};
   endfunction

   function automatic logic [VAL_W-1:0] clamp_load(input logic [VAL_W-1:0] v);
      return (v > MAX_V) ? MAX_V : v;
   endfunction

   logic [ADC_W-1:0] axis_q;
   state_t           state_q, state_d;
   dir_t             dir_q, dir_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_up, req_dn;
   logic             press_up, press_dn, released;
   logic [VAL_W-1:0] value_d;
   logic             step_up_d, step_dn_d, limit_d;
   logic [VAL_W:0]   bump;

   assign press_up = axis_q > PRESS_UP;
   assign press_dn = axis_q < PRESS_DN;
   // A reversal past the opposite threshold also satisfies these, so it ends the hold.
   assign released = (dir_q == DIR_UP) ? (axis_q <= RELEASE_UP) : (axis_q >= RELEASE_DN);
   assign held     = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      req_up  = 1'b0;
      req_dn  = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (press_up) begin
                  state_d = FIRST;
                  dir_d   = DIR_UP;
                  req_up  = 1'b1;
               end else if (press_dn) begin
                  state_d = FIRST;
                  dir_d   = DIR_DN;
                  req_dn  = 1'b1;
               end
            end
            FIRST: begin
               if (released) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == FIRST_LAST) begin
                  state_d = REPEAT;
                  cnt_d   = '0;
                  req_up  = (dir_q == DIR_UP);
                  req_dn  = (dir_q == DIR_DN);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            REPEAT: begin
               if (released) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == REPEAT_LAST) begin
                  cnt_d  = '0;
                  req_up = (dir_q == DIR_UP);
                  req_dn = (dir_q == DIR_DN);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Load wins over any step requested in the same cycle and leaves the FSM untouched.
   always_comb begin
      value_d   = value;
      step_up_d = 1'b0;
      step_dn_d = 1'b0;
      limit_d   = 1'b0;
      bump      = '0;
      if (load) begin
         value_d = clamp_load(load_value);
      end else if (req_up) begin
         bump      = inc_val(value);
         value_d   = bump[VAL_W-1:0];
         step_up_d = ~bump[VAL_W];
         limit_d   = bump[VAL_W];
      end else if (req_dn) begin
         bump      = dec_val(value);
         value_d   = bump[VAL_W-1:0];
         step_dn_d = ~bump[VAL_W];
         limit_d   = bump[VAL_W];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         axis_q    <= '0;
         state_q   <= IDLE;
         dir_q     <= DIR_UP;
         cnt_q     <= '0;
         value     <= RESET_V;
         step_up   <= 1'b0;
         step_down <= 1'b0;
         at_limit  <= 1'b0;
      end else begin
         axis_q    <= axis_value;
         state_q   <= state_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
         value     <= value_d;
         step_up   <= step_up_d;
         step_down <= step_dn_d;
         at_limit  <= limit_d;
      end
   end

endmodule

// File: tb/tb_joystick_selector.sv
// Scoreboard bench for joystick_selector: a wrap-mode and a saturate-mode instance share
// stimulus; a press/elapsed-time model predicts pulses (queued) and per-cycle value/held.
module tb_joystick_selector;

   localparam int FD = 8;
   localparam int RD = 4;
   localparam int HI = 12'h750;
   localparam int LO = 12'h500;
   localparam int HY = 12'h040;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, enable, load;
   logic [11:0] axis;
   logic [3:0]  load_value;
   logic [3:0]  val0, val1;
   logic        up0, dn0, held0, lim0;
   logic        up1, dn1, held1, lim1;

   joystick_selector #(.VAL_W(4), .MAX_VAL(15), .WRAP(1), .FIRST_DELAY(FD), .REPEAT_DELAY(RD))
   dut_wrap (.clk(clk), .reset(reset), .enable(enable), .axis_value(axis), .load(load),
             .load_value(load_value), .value(val0), .step_up(up0), .step_down(dn0),
             .held(held0), .at_limit(lim0));

   joystick_selector #(.VAL_W(4), .MAX_VAL(9), .WRAP(0), .FIRST_DELAY(FD), .REPEAT_DELAY(RD))
   dut_sat (.clk(clk), .reset(reset), .enable(enable), .axis_value(axis), .load(load),
            .load_value(load_value), .value(val1), .step_up(up1), .step_down(dn1),
            .held(held1), .at_limit(lim1));

   typedef struct {int tag; int kind; int val;} ev_t;  // kind: 0 up, 1 down, 2 limit
   ev_t q0[$];
   ev_t q1[$];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   int m_val[2];
   int m_t[2];
   bit m_act[2];
   bit m_dn[2];
   int m_axq;
   int mx[2]   = '{15, 9};
   bit wrap[2] = '{1'b1, 1'b0};
   bit first_call = 1'b1;
   logic [11:0] tbl [0:11] = '{12'h100, 12'h4FF, 12'h500, 12'h53F, 12'h540, 12'h600,
                               12'h710, 12'h711, 12'h750, 12'h751, 12'h800, 12'hFFF};

   function automatic void check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endfunction

   function automatic void push_ev(int i, int kind, int val);
      ev_t e;
      e.tag  = cyc + 1;
      e.kind = kind;
      e.val  = val;
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
   endfunction

   // Reference: a press starts at elapsed time 0; steps fall at 0, FD, FD+RD, FD+2RD...
   function automatic void model_edge(int ax, bit en, bit ld, int lv, bit rs);
      for (int i = 0; i < 2; i++) begin
         bit step = 1'b0;
         bit rel;
         if (rs) begin
            m_val[i] = 0;
            m_act[i] = 1'b0;
            m_dn[i]  = 1'b0;
            m_t[i]   = 0;
         end else begin
            if (!en) begin
               m_act[i] = 1'b0;
            end else if (!m_act[i]) begin
               if (m_axq > HI) begin
                  m_act[i] = 1'b1; m_dn[i] = 1'b0; m_t[i] = 0; step = 1'b1;
               end else if (m_axq < LO) begin
                  m_act[i] = 1'b1; m_dn[i] = 1'b1; m_t[i] = 0; step = 1'b1;
               end
            end else begin
               m_t[i]++;
               rel = m_dn[i] ? (m_axq >= LO + HY) : (m_axq <= HI - HY);
               if (rel) m_act[i] = 1'b0;
               else if (m_t[i] == FD || (m_t[i] > FD && (m_t[i] - FD) % RD == 0)) step = 1'b1;
            end
            if (ld) begin
               m_val[i] = (lv > mx[i]) ? mx[i] : lv;
            end else if (step && !m_dn[i]) begin
               if (m_val[i] == mx[i]) begin
                  if (wrap[i]) begin m_val[i] = 0; push_ev(i, 0, m_val[i]); end
                  else push_ev(i, 2, m_val[i]);
               end else begin
                  m_val[i]++; push_ev(i, 0, m_val[i]);
               end
            end else if (step) begin
               if (m_val[i] == 0) begin
                  if (wrap[i]) begin m_val[i] = mx[i]; push_ev(i, 1, m_val[i]); end
                  else push_ev(i, 2, m_val[i]);
               end else begin
                  m_val[i]--; push_ev(i, 1, m_val[i]);
               end
            end
         end
      end
      m_axq = rs ? 0 : ax;
   endfunction

   task automatic drive(input logic [11:0] ax, input logic en, input logic ld,
                        input logic [3:0] lv, input logic rs);
      @(negedge clk);
      if (!first_call) begin
         check("value_wrap", int'(val0), m_val[0]);
         check("value_sat", int'(val1), m_val[1]);
         check("held_wrap", int'(held0), int'(m_act[0]));
         check("held_sat", int'(held1), int'(m_act[1]));
      end
      first_call = 1'b0;
      axis = ax; enable = en; load = ld; load_value = lv; reset = rs;
      model_edge(int'(ax), en, ld, int'(lv), rs);
   endtask

   task automatic hold(input logic [11:0] ax, input int n);
      for (int k = 0; k < n; k++) drive(ax, 1'b1, 1'b0, 4'h0, 1'b0);
   endtask

   function automatic void mon_one(int i, logic up, logic dn, logic lim, logic [3:0] v);
      ev_t e;
      bit have;
      int n;
      int kind;
      n = int'(up) + int'(dn) + int'(lim);
      if (i == 0) have = (q0.size() > 0) && (q0[0].tag == cyc);
      else        have = (q1.size() > 0) && (q1[0].tag == cyc);
      if (n > 0 || have) begin
         check(i == 0 ? "pulse_count_wrap" : "pulse_count_sat", n, int'(have));
         if (have) begin
            if (i == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (n == 1) begin
               kind = up ? 0 : (dn ? 1 : 2);
               check(i == 0 ? "pulse_kind_wrap" : "pulse_kind_sat", kind, e.kind);
               check(i == 0 ? "pulse_value_wrap" : "pulse_value_sat", int'(v), e.val);
            end
         end
      end
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         mon_one(0, up0, dn0, lim0, val0);
         mon_one(1, up1, dn1, lim1, val1);
      end
   end

   initial begin
      reset = 1'b1; enable = 1'b1; load = 1'b0; load_value = 4'h0; axis = 12'h600;
      m_axq = 0;
      for (int i = 0; i < 2; i++) begin
         m_val[i] = 0; m_t[i] = 0; m_act[i] = 1'b0; m_dn[i] = 1'b0;
      end

      for (int k = 0; k < 3; k++) drive(12'h600, 1'b1, 1'b0, 4'h0, 1'b1);
      drive(12'h600, 1'b0, 1'b0, 4'h0, 1'b0);
      hold(12'h600, 3);

      // single tap
      hold(12'h800, 3);
      hold(12'h600, 5);
      // long hold with auto-repeat
      hold(12'h800, 30);
      hold(12'h600, 4);
      // step below zero: wrap vs saturate
      drive(12'h600, 1'b1, 1'b1, 4'h0, 1'b0);
      hold(12'h600, 2);
      hold(12'h100, 2);
      hold(12'h600, 4);
      // hysteresis band then reversal
      hold(12'h800, 10);
      hold(12'h720, 6);
      hold(12'h400, 4);
      hold(12'h600, 4);
      // load colliding with a press step
      drive(12'h800, 1'b1, 1'b0, 4'h0, 1'b0);
      drive(12'h800, 1'b1, 1'b1, 4'hF, 1'b0);
      hold(12'h800, 3);
      hold(12'h600, 4);
      // reset mid-hold with the stick still deflected
      hold(12'h800, 7);
      drive(12'h800, 1'b1, 1'b0, 4'h0, 1'b1);
      hold(12'h800, 4);
      hold(12'h600, 4);
      // enable low during a hold, load still applies
      hold(12'h800, 5);
      drive(12'h800, 1'b0, 1'b0, 4'h0, 1'b0);
      drive(12'h800, 1'b0, 1'b1, 4'h7, 1'b0);
      drive(12'h800, 1'b0, 1'b0, 4'h0, 1'b0);
      hold(12'h800, 5);
      hold(12'h600, 3);

      for (int s = 0; s < 70; s++) begin
         logic [11:0] ax;
         int len;
         ax  = ($urandom_range(0, 4) == 0) ? 12'($urandom) : tbl[$urandom_range(0, 11)];
         len = $urandom_range(1, 20);
         for (int k = 0; k < len; k++)
            drive(ax, ($urandom % 16) != 0, ($urandom % 20) == 0, 4'($urandom),
                  ($urandom % 80) == 0);
      end

      hold(12'h600, 5);
      @(negedge clk);
      @(negedge clk);
      check("queue_empty_wrap", q0.size(), 0);
      check("queue_empty_sat", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
